// File: rtl/ysyx_24100029_pkg.sv
// Shared constants for the pipeline control slice.
//   ST_RUN / ST_MEM_WAIT / ST_TRAP : pipe_ctrl FSM encodings (3 unused, decodes to RUN)
//   REG_W                          : architectural register index width
package ysyx_24100029_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;

endpackage

// File: rtl/ysyx_24100029_sat_cnt.sv
// Saturating up-counter: advances by one on each cycle with inc=1 and
// sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset (clears to 0)
//   inc      : count enable
//   cnt      : current count
module ysyx_24100029_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24100029_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Resolves load-use hazards,
// freezes the pipe while an LSU access is outstanding, and squashes
// wrong-path work on EXU redirects and WBU traps.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   RUN       | normal flow; load-use bubbles and redirect flushes
//   MEM_WAIT  | LSU access outstanding, IFU..MEM held until MEM_done
//   TRAP      | one cycle after a trap, re-flush IFU/IDU (stale fetch)
//
// Inputs : clk, rst, IDU_* (source operands), EXU_* (destination, load,
//          redirect), MEM_req/MEM_done (LSU handshake), WBU_trap
// Outputs: per-stage *_stall / *_flush, EXU_bubble, ctrl_state (debug),
//          stall_cnt / flush_cnt (saturating performance counters)
import ysyx_24100029_pkg::*;

module ysyx_24100029_pipe_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = ysyx_24100029_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDU_valid,
  input  logic [REG_W-1:0] IDU_rs1,
  input  logic [REG_W-1:0] IDU_rs2,
  input  logic             IDU_rs1_used,
  input  logic             IDU_rs2_used,
  input  logic             EXU_valid,
  input  logic [REG_W-1:0] EXU_rd,
  input  logic             EXU_mem_ren,
  input  logic             EXU_redirect,
  input  logic             MEM_req,
  input  logic             MEM_done,
  input  logic             WBU_trap,
  output logic             IFU_stall,
  output logic             IDU_stall,
  output logic             EXU_stall,
  output logic             MEM_stall,
  output logic             EXU_bubble,
  output logic             IFU_flush,
  output logic             IDU_flush,
  output logic             EXU_flush,
  output logic             MEM_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pending;
  logic       lu;
  logic       flush_ev;
  logic       pipe_free;

  assign lu = EXU_valid && IDU_valid && EXU_mem_ren && (EXU_rd != '0) &&
              ((IDU_rs1_used && (IDU_rs1 == EXU_rd)) ||
               (IDU_rs2_used && (IDU_rs2 == EXU_rd)));

  // A zero-wait access (req and done together) never sets the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (MEM_done) begin
      pending <= 1'b0;
    end else if (MEM_req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Each branch drives either stalls or flushes, never both, so a stage
  // can never see stall and flush together.
  always_comb begin
    state_nxt  = ST_RUN;
    IFU_stall  = 1'b0;
    IDU_stall  = 1'b0;
    EXU_stall  = 1'b0;
    MEM_stall  = 1'b0;
    EXU_bubble = 1'b0;
    IFU_flush  = 1'b0;
    IDU_flush  = 1'b0;
    EXU_flush  = 1'b0;
    MEM_flush  = 1'b0;
    flush_ev   = 1'b0;
    pipe_free  = 1'b0;
    if (!rst) begin
      case (state)
        ST_MEM_WAIT: begin
          if (WBU_trap) begin
            {IFU_flush, IDU_flush, EXU_flush, MEM_flush} = 4'b1111;
            flush_ev  = 1'b1;
            state_nxt = ST_TRAP;
          end else if (!MEM_done) begin
            {IFU_stall, IDU_stall, EXU_stall, MEM_stall} = 4'b1111;
            state_nxt = ST_MEM_WAIT;
          end else begin
            // The pipe moves again this cycle, so whatever EXU/IDU hold
            // now must get the normal redirect/load-use treatment.
            pipe_free = 1'b1;
          end
        end
        ST_TRAP: begin
          IFU_flush = 1'b1;
          IDU_flush = 1'b1;
        end
        default: begin
          if (WBU_trap) begin
            {IFU_flush, IDU_flush, EXU_flush, MEM_flush} = 4'b1111;
            flush_ev  = 1'b1;
            state_nxt = ST_TRAP;
          end else if (pending && !MEM_done) begin
            {IFU_stall, IDU_stall, EXU_stall, MEM_stall} = 4'b1111;
            state_nxt = ST_MEM_WAIT;
          end else begin
            pipe_free = 1'b1;
          end
        end
      endcase

      if (pipe_free) begin
        if (EXU_redirect) begin
          // The load-use consumer is on the wrong path; squash, don't stall.
          IFU_flush = 1'b1;
          IDU_flush = 1'b1;
          flush_ev  = 1'b1;
        end else if (lu) begin
          IFU_stall  = 1'b1;
          IDU_stall  = 1'b1;
          EXU_bubble = 1'b1;
        end
      end
    end
  end

  assign ctrl_state = state;

  ysyx_24100029_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (IDU_stall),
    .cnt (stall_cnt)
  );

  ysyx_24100029_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_ev),
    .cnt (flush_cnt)
  );

endmodule
